// File: rtl/switch_stream.sv
// Streaming word switch: per-word swap/reverse/rotl1/AUTO transform into a DEPTH-entry output FIFO.
// Optional AUTO resolution counters are built when SWITCH_STATS_EN is defined.
module switch_stream #(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic [1:0]   in_mode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [1:0]   out_op,
    output logic [15:0]  auto_swap_cnt,
    output logic [15:0]  auto_rev_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    localparam logic [1:0] MODE_AUTO = 2'b00;
    localparam logic [1:0] MODE_SWAP = 2'b01;
    localparam logic [1:0] MODE_REV  = 2'b10;

    localparam logic [1:0] OP_SWAP = 2'b00;
    localparam logic [1:0] OP_REV  = 2'b01;
    localparam logic [1:0] OP_ROTL = 2'b10;

    typedef struct packed {
        logic [1:0]   op;
        logic [W-1:0] data;
    } entry_t;

    entry_t         mem [DEPTH];
    logic [AW-1:0]  rd_ptr, wr_ptr, rd_n, wr_n;
    logic [CW-1:0]  cnt, cnt_n;
    logic           push, pop, uniform;
    logic [W-1:0]   swp, rev, rot;
    entry_t         xf, head;

    // Candidate transforms and mode resolution
    always_comb begin
        swp     = {in_data[W/2-1:0], in_data[W-1:W/2]};
        rev     = {<<{in_data}};
        rot     = {in_data[W-2:0], in_data[W-1]};
        uniform = (in_data == '0) || (in_data == '1);
        xf      = '{op: OP_SWAP, data: swp};
        case (in_mode)
            MODE_AUTO: xf = uniform ? '{op: OP_REV, data: rev} : '{op: OP_SWAP, data: swp};
            MODE_SWAP: xf = '{op: OP_SWAP, data: swp};
            MODE_REV:  xf = '{op: OP_REV,  data: rev};
            default:   xf = '{op: OP_ROTL, data: rot};
        endcase
    end

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    // Next pointer/occupancy state; the new head bypasses memory when it is the word being written
    always_comb begin
        rd_n  = rd_ptr;
        wr_n  = wr_ptr;
        cnt_n = cnt;
        if (push) wr_n = wr_ptr + AW'(1);
        if (pop)  rd_n = rd_ptr + AW'(1);
        case ({push, pop})
            2'b10:   cnt_n = cnt + CW'(1);
            2'b01:   cnt_n = cnt - CW'(1);
            default: cnt_n = cnt;
        endcase
        head = (push && (wr_ptr == rd_n)) ? xf : mem[rd_n];
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= xf;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            out_data  <= '0;
            out_op    <= OP_SWAP;
        end else begin
            rd_ptr    <= rd_n;
            wr_ptr    <= wr_n;
            cnt       <= cnt_n;
            out_valid <= (cnt_n != '0);
            in_ready  <= (cnt_n != CW'(DEPTH));
            if (cnt_n != '0) begin
                out_data <= head.data;
                out_op   <= head.op;
            end
        end
    end

`ifdef SWITCH_STATS_EN
    // Saturating AUTO resolution counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            auto_swap_cnt <= '0;
            auto_rev_cnt  <= '0;
        end else if (push && (in_mode == MODE_AUTO)) begin
            if (uniform) begin
                if (auto_rev_cnt != 16'hFFFF) auto_rev_cnt <= auto_rev_cnt + 16'd1;
            end else begin
                if (auto_swap_cnt != 16'hFFFF) auto_swap_cnt <= auto_swap_cnt + 16'd1;
            end
        end
    end
`else
    assign auto_swap_cnt = 16'h0000;
    assign auto_rev_cnt  = 16'h0000;
`endif

endmodule

// File: doc/switch_stream.md
# switch_stream

Streaming, parametrised successor to the byte switch. Each accepted W-bit word is transformed by a per-word mode: swap halves, reverse bits, rotate left by one, or the AUTO rule. In AUTO, a non-uniform word gets its halves swapped and a uniform word gets its bits reversed. Results are queued in a DEPTH-entry output FIFO behind valid/ready handshakes on both sides. The block sits between a producer and a consumer stage of the datapath and replaces the combinational switch wherever back-pressure exists.

## Interface
- W, 8, data width; even, ≥ 4.
- DEPTH, 2, output FIFO entries; power of 2, ≥ 2.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; asynchronous, active-low.
- in_valid  input  1  producer offers in_data/in_mode.
- in_ready  output  1  block can accept; high exactly when the FIFO is not full.
- in_data  input  W  word to transform.
- in_mode  input  2  mode code: 00 AUTO, 01 SWAP, 10 REVERSE, 11 ROTL1.
- out_valid  output  1  FIFO head valid.
- out_ready  input  1  consumer takes the head.
- out_data  output  W  transformed word at the FIFO head.
- out_op  output  2  operation actually applied: 00 swap, 01 reverse, 10 rotl1.
- auto_swap_cnt  output  16  AUTO words resolved to swap (see Configuration).
- auto_rev_cnt  output  16  AUTO words resolved to reverse (see Configuration).

## Operation
- Accept: in_valid && in_ready at a rising edge.
- Transform is combinational on in_data; the result and its op code are written into the FIFO on accept.
- SWAP: out[W-1:W/2] = in[W/2-1:0]; out[W/2-1:0] = in[W-1:W/2].
- REVERSE: out[k] = in[W-1-k] for all k.
- ROTL1: out = {in[W-2:0], in[W-1]}.
- AUTO:
  - "Uniform" means every adjacent pair in[k], in[k+1] is equal for k = 0..W-2, i.e. all zeros or all ones.
  - Uniform word → REVERSE, op 01. The data is unchanged but the op is still reported.
  - Non-uniform word → SWAP, op 00.
- Release: out_valid && out_ready at a rising edge pops the head.
- FIFO:
  - Circular read/write pointers of log2(DEPTH) bits, plus an occupancy count of log2(DEPTH)+1 bits.
  - Pointers wrap from DEPTH-1 to 0.
  - Output order equals acceptance order.
- Full: in_ready = 0, and no push occurs even if a pop happens in the same cycle. There is no full-cycle pass-through.
- Empty: out_valid = 0; out_data and out_op hold their last values and carry no meaning.
- Simultaneous push and pop when neither full nor empty: occupancy is unchanged and both pointers advance.
- out_valid only drops after a pop. out_data and out_op stay stable while out_valid && !out_ready.
- Reset (at any time, including mid-transfer):
  - FIFO flushed; occupancy 0.
  - out_valid = 0, in_ready = 1.
  - out_data = 0, out_op = 00.
  - Counters = 0.

## Timing
- Latency: a word accepted at edge N appears with out_valid = 1 after edge N, if the FIFO was empty. There is no combinational path from in_* to out_*.
- in_ready depends only on registered occupancy; it has no combinational path from out_ready.
- Throughput: one word per cycle while the consumer drains every cycle.
- Reset takes effect immediately when asserted. The first accept is possible at the first rising edge after rst_n deasserts.

## Configuration
- SWITCH_STATS_EN defined:
  - auto_swap_cnt and auto_rev_cnt each increment by 1 on every accepted AUTO word that resolves to their operation.
  - Both saturate at 16'hFFFF.
  - Both clear only on reset.
- SWITCH_STATS_EN undefined:
  - The counters are not implemented.
  - Both ports are tied to 16'h0000.
  - All other behaviour is identical.

## Test plan
- W=8, AUTO, in_data 8'hF0 → out_data 8'h0F, out_op 00, one cycle after accept; with stats enabled, auto_swap_cnt = 1.
- AUTO, 8'hFF, then 8'h00 → out_data 8'hFF then 8'h00, out_op 01 for both; with stats enabled, auto_rev_cnt = 2.
- REVERSE, 8'hFE → 8'h7F, op 01. ROTL1, 8'h81 → 8'h03, op 10. SWAP, 8'hA5 → 8'h5A, op 00.
- DEPTH=2, out_ready = 0, offer 8'h12, 8'h34, 8'h56 (SWAP):
  - in_ready falls after the second accept; the third word is held.
  - Raise out_ready → 8'h21, 8'h43, 8'h65 emerge in order, and in_ready recovers the cycle after the first pop.
- Continuous stream of 16 words with out_ready = 1 → one output per cycle; pointers wrap with no loss or duplication.
- Assert rst_n = 0 with 2 words queued → out_valid = 0, in_ready = 1, out_data = 0 immediately. After release, a new word gets single-cycle latency.
